// File: rtl/issue_queue.sv
// Dual-issue instruction buffer between fetch and decode.
// Fetch pairs are absorbed into a circular queue; up to two entries are
// presented to decode each cycle. The pair is split to single issue when
// the younger instruction reads a register the older one writes, or when
// the older one is a control-flow instruction.
module issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   InstrA,
    input  logic [DATA_WIDTH-1:0]   InstrB,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_instrA,
    output logic [DATA_WIDTH-1:0]   out_instrB,
    output logic                    out_validA,
    output logic                    out_validB,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] NOP       = DATA_WIDTH'(32'h0000_0013);
    localparam logic [CW-1:0]         FREE2_MAX = CW'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic [PW-1:0]         w_head1;
    logic [PW-1:0]         w_tail1;
    logic [DATA_WIDTH-1:0] w_entA;
    logic [DATA_WIDTH-1:0] w_entB;
    logic                  w_ctrlA;
    logic                  w_wrA;
    logic                  w_raw;
    logic                  w_pair_ok;
    logic                  w_push;
    logic [1:0]            w_pop;
    logic [CW-1:0]         w_count_next;

    // Older instruction redirects the PC (branch, jal, jalr).
    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
    endfunction

    // Opcode produces a register result.
    function automatic logic writes_rd(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
               (op == 7'b0110111) || (op == 7'b0010111) || (op == 7'b1101111) ||
               (op == 7'b1100111);
    endfunction

    // lui, auipc and jal have no rs1 field.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == 7'b0110111) || (op == 7'b0010111) || (op == 7'b1101111));
    endfunction

    // R-type, stores and branches read rs2.
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    endfunction

    assign w_head1 = r_head + PW'(1);
    assign w_tail1 = r_tail + PW'(1);
    assign w_entA  = r_mem[r_head];
    assign w_entB  = r_mem[w_head1];

    // Pairing hazard check between head and head+1.
    always_comb begin
        w_ctrlA   = is_ctrl(w_entA[6:0]);
        w_wrA     = writes_rd(w_entA[6:0]) && (w_entA[11:7] != 5'd0);
        w_raw     = w_wrA &&
                    ((uses_rs1(w_entB[6:0]) && (w_entB[19:15] == w_entA[11:7])) ||
                     (uses_rs2(w_entB[6:0]) && (w_entB[24:20] == w_entA[11:7])));
        w_pair_ok = !w_ctrlA && !w_raw;
    end

    // Lane presentation and flow control, all from registered state.
    always_comb begin
        in_ready     = (r_count <= FREE2_MAX);
        out_validA   = (r_count != '0);
        out_validB   = (r_count >= CW'(2)) && w_pair_ok;
        out_instrA   = out_validA ? w_entA : NOP;
        out_instrB   = out_validB ? w_entB : NOP;
        count        = r_count;
        w_push       = in_valid && in_ready && !flush;
        w_pop        = out_ready ? ({1'b0, out_validA} + {1'b0, out_validB}) : 2'd0;
        w_count_next = r_count + (w_push ? CW'(2) : CW'(0)) - CW'(w_pop);
    end

    // Entry storage: write the fetch pair at tail and tail+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= NOP;
            end
        end else if (w_push) begin
            r_mem[r_tail]  <= InstrA;
            r_mem[w_tail1] <= InstrB;
        end
    end

    // Pointer and occupancy update; flush discards everything, including this cycle's pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(2);
            end
            r_head  <= r_head + PW'(w_pop);
            r_count <= w_count_next;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with a scoreboard of expected issued
// instructions and a negedge monitor that consumes it as decode accepts lanes.
module tb_issue_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] InstrA;
    logic [31:0] InstrB;
    logic        in_ready;
    logic [31:0] out_instrA;
    logic [31:0] out_instrB;
    logic        out_validA;
    logic        out_validB;
    logic        out_ready;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] instr;
        bit          laneB;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    issue_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .InstrA(InstrA), .InstrB(InstrB), .in_ready(in_ready),
        .out_instrA(out_instrA), .out_instrB(out_instrB),
        .out_validA(out_validA), .out_validB(out_validB),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_issue(input logic [31:0] instr, input bit laneB);
        exp_t e;
        e.instr = instr;
        e.laneB = laneB;
        sbq.push_back(e);
    endtask

    // Monitor: whenever decode accepts, pop expected lane A (and lane B if paired).
    always @(negedge clk) begin
        exp_t e;
        bit   expB;
        if (!rst && out_ready && out_validA) begin
            if (sbq.size() == 0) begin
                check("unexpected_issue", {31'd0, out_validA}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("laneA_instr", out_instrA, e.instr);
                expB = (sbq.size() > 0) && sbq[0].laneB;
                check("laneB_valid", {31'd0, out_validB}, {31'd0, expB});
                if (expB) begin
                    e = sbq.pop_front();
                    check("laneB_instr", out_instrB, e.instr);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        InstrA = '0; InstrB = '0;
        #2;
        check("rst_count",    {29'd0, count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_validA",   {31'd0, out_validA}, 32'd0);
        check("rst_validB",   {31'd0, out_validB}, 32'd0);
        check("rst_instrA",   out_instrA, NOP);
        check("rst_instrB",   out_instrB, NOP);
        #10 rst = 1'b0;
        step();

        // Independent pair issues together.
        out_ready = 1'b1; in_valid = 1'b1;
        InstrA = 32'h0050_0093; InstrB = 32'h0070_0193;
        expect_issue(32'h0050_0093, 1'b0);
        expect_issue(32'h0070_0193, 1'b1);
        step();
        in_valid = 1'b0;
        check("indep_count2", {29'd0, count}, 32'd2);
        step();
        check("indep_count0", {29'd0, count}, 32'd0);

        // RAW dependency splits the pair.
        in_valid = 1'b1;
        InstrA = 32'h0050_0093; InstrB = 32'h0010_8133;
        expect_issue(32'h0050_0093, 1'b0);
        expect_issue(32'h0010_8133, 1'b0);
        step();
        in_valid = 1'b0;
        check("raw_count2", {29'd0, count}, 32'd2);
        step();
        check("raw_count1", {29'd0, count}, 32'd1);
        step();
        check("raw_count0", {29'd0, count}, 32'd0);

        // Branch on lane A blocks lane B; flush drops queue and incoming pair.
        out_ready = 1'b0; in_valid = 1'b1;
        InstrA = 32'h0000_0463; InstrB = 32'h0070_0193;
        step();
        in_valid = 1'b0;
        check("ctrl_count",  {29'd0, count}, 32'd2);
        check("ctrl_validA", {31'd0, out_validA}, 32'd1);
        check("ctrl_validB", {31'd0, out_validB}, 32'd0);
        check("ctrl_instrA", out_instrA, 32'h0000_0463);
        check("ctrl_instrB", out_instrB, NOP);
        flush = 1'b1; in_valid = 1'b1;
        InstrA = 32'h0010_0093; InstrB = 32'h0020_0113;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count",    {29'd0, count}, 32'd0);
        check("flush_validA",   {31'd0, out_validA}, 32'd0);
        check("flush_validB",   {31'd0, out_validB}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);

        // Fill to capacity under backpressure; third pair must be ignored.
        in_valid = 1'b1;
        InstrA = 32'h0010_0093; InstrB = 32'h0020_0113;
        expect_issue(32'h0010_0093, 1'b0);
        expect_issue(32'h0020_0113, 1'b1);
        step();
        InstrA = 32'h0030_0193; InstrB = 32'h0040_0213;
        expect_issue(32'h0030_0193, 1'b0);
        expect_issue(32'h0040_0213, 1'b1);
        step();
        check("full_count",    {29'd0, count}, 32'd4);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        InstrA = 32'h0050_0293; InstrB = 32'h0060_0313;
        step();
        in_valid = 1'b0;
        check("full_ignore_count", {29'd0, count}, 32'd4);
        out_ready = 1'b1;
        step();
        check("drain_count2", {29'd0, count}, 32'd2);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("drain_count0", {29'd0, count}, 32'd0);

        // Simultaneous push and pop keeps occupancy at two.
        out_ready = 1'b0; in_valid = 1'b1;
        InstrA = 32'h0070_0393; InstrB = 32'h0080_0413;
        expect_issue(32'h0070_0393, 1'b0);
        expect_issue(32'h0080_0413, 1'b1);
        step();
        check("sim_pre_count", {29'd0, count}, 32'd2);
        out_ready = 1'b1;
        InstrA = 32'h0090_0493; InstrB = 32'h00a0_0513;
        expect_issue(32'h0090_0493, 1'b0);
        expect_issue(32'h00a0_0513, 1'b1);
        step();
        in_valid = 1'b0;
        check("sim_count", {29'd0, count}, 32'd2);
        check("sim_instrA", out_instrA, 32'h0090_0493);
        step();
        check("sim_drain_count", {29'd0, count}, 32'd0);

        // Asynchronous reset mid-operation clears without a clock edge.
        out_ready = 1'b0; in_valid = 1'b1;
        InstrA = 32'h0010_0093; InstrB = 32'h0020_0113;
        step();
        in_valid = 1'b0;
        check("pre_async_count", {29'd0, count}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("async_count",  {29'd0, count}, 32'd0);
        check("async_validA", {31'd0, out_validA}, 32'd0);
        check("async_instrA", out_instrA, NOP);
        #1 rst = 1'b0;
        step();
        step();

        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Dual-issue instruction buffer between the fetch stage (InstrA/InstrB pair per cycle) and the decode stage.
- Absorbs fetch pairs into a circular queue and presents up to two instructions per cycle to decode.
- Splits a pair into single issue when the second instruction depends on the first (RAW) or follows a control-flow instruction.
- Discards all contents on a PC redirect (flush).

Parameters:
DATA_WIDTH, 32, instruction width in bits
DEPTH, 4, queue entries; power of two, at least 2

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  redirect (PCSrc taken); discard all queued entries
in_valid  input  1  fetch presents a valid pair on InstrA/InstrB
InstrA  input  DATA_WIDTH  older fetched instruction
InstrB  input  DATA_WIDTH  younger fetched instruction
in_ready  output  1  queue can accept a pair (free entries >= 2)
out_instrA  output  DATA_WIDTH  instruction issued on lane A (queue head)
out_instrB  output  DATA_WIDTH  instruction issued on lane B (head+1)
out_validA  output  1  lane A holds a valid instruction
out_validB  output  1  lane B holds a valid instruction
out_ready  input  1  decode consumes the valid lanes this cycle
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst=1): head/tail pointers=0, count=0, storage cleared to NOP 0x00000013, out_validA=out_validB=0, out_instrA=out_instrB=0x00000013, in_ready=1.
- Storage: DEPTH x DATA_WIDTH registers with head, tail and count registers. Pointers wrap modulo DEPTH.
- in_ready = (DEPTH - count) >= 2. Combinational from registered count only; does not depend on a same-cycle pop.
- Push: when in_valid && in_ready at a rising edge, write InstrA to tail and InstrB to tail+1. tail += 2.
- Enqueue latency: a pair pushed at edge N is visible on the outputs in the cycle after edge N.
- Outputs are combinational from storage.
  - out_validA = count >= 1.
  - out_validB = count >= 2 && pair_ok.
  - An invalid lane drives 0x00000013.
- pair_ok is computed on head (A) and head+1 (B):
  - ctrlA: A opcode is 1100011, 1101111 or 1100111.
  - wrA: A opcode is 0110011, 0010011, 0000011, 0110111, 0010111, 1101111 or 1100111, and A.rd != 0.
  - B uses rs1 unless its opcode is 0110111, 0010111 or 1101111.
  - B uses rs2 when its opcode is 0110011, 0100011 or 1100011.
  - raw = wrA && ((usesRs1B && B.rs1==A.rd) || (usesRs2B && B.rs2==A.rd)).
  - pair_ok = !ctrlA && !raw.
- Pop: when out_ready=1, remove out_validA + out_validB entries (0, 1 or 2). head advances by the same amount.
- Simultaneous push and pop: count_next = count + 2*push - pop. Never overflows because of the in_ready rule.
- Empty: no pop occurs even if out_ready=1.
- Single entry remaining: issues on lane A only.
- Flush: synchronous, at the next edge. head=tail=count=0. Overrides any push and pop in the same cycle; the fetch pair presented that cycle is dropped. out_validA/B are low in the following cycle.
- Reset asserted mid-operation: immediate clear to reset state regardless of clock. Operation resumes on the first edge after rst deasserts.
- Full (count=DEPTH) or count=DEPTH-1: in_ready=0; in_valid is ignored.

Test Plan:
- Reset then idle: rst pulse -> count=0, in_ready=1, out_validA=out_validB=0, both out_instr=0x00000013.
- Independent pair: push A=0x00500093 (addi x1,x0,5), B=0x00700193 (addi x3,x0,7), out_ready=1 -> next cycle validA=validB=1 with those values; count 2->0 after the edge.
- RAW split: push A=0x00500093, B=0x00108133 (add x2,x1,x1) -> cycle 1 validA=1, validB=0, lane A=0x00500093. After the pop, lane A=0x00108133. count 2->1->0.
- Control split and flush: push A=0x00000463 (beq), B=0x00700193 -> only A valid. Then assert flush together with in_valid on a new pair -> next cycle count=0, both valids 0, new pair dropped.
- Full/backpressure: out_ready=0, push two pairs -> count=4, in_ready=0. A third in_valid pair is ignored. Raise out_ready with independent pairs -> count 4->2->0 in order.
- Simultaneous push/pop: count=2 (independent), out_ready=1, push a new pair same edge -> count stays 2; the new pair appears on lanes A/B next cycle.
